ram_port_arbiter: RTL and testbench

- Parametrised multi-channel front end for the single-port synchronous `ram`; supersedes the two-channel read-only `ram2`.
- Serves NUM_PORTS requesters (fetch stage, operand stage, future write-back) with reads and writes.
- Uses round-robin arbitration and a level-request / ready-pulse handshake.
- Sits between the pipeline stages and `ram`, and drives ram's write_enable, address and data_in directly.

---
 rtl/ram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Round-robin multi-port front end for the single-port synchronous ram.
// Each requester holds req until its one-cycle ready pulse; one transaction is in flight at a time.
module ram_port_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                                               ram_clk,
  input  logic                                               rst,
  input  logic [NUM_PORTS-1:0]                               req,
  input  logic [NUM_PORTS-1:0]                               we,
  input  logic [NUM_PORTS*ADDR_W-1:0]                        addr,
  input  logic [NUM_PORTS*DATA_W-1:0]                        wdata,
  output logic [NUM_PORTS-1:0]                               ready,
  output logic [NUM_PORTS*DATA_W-1:0]                        rdata,
  output logic                                               busy,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_id,
  output logic                                               ram_write_enable,
  output logic [ADDR_W-1:0]                                  ram_address,
  output logic [DATA_W-1:0]                                  ram_data_in,
  input  logic [DATA_W-1:0]                                  ram_data_out
);

  // state | meaning
  // IDLE  | waiting for any req; grant and drive the ram bus on the next edge
  // ISSUE | ram samples address/data/write_enable on this edge
  // WAIT  | counting down ram read latency, then capture data and pulse ready
  // DONE  | ready is high for this single cycle; req is ignored here

  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state, state_next;
  logic [GW-1:0]       ptr, ptr_next, grant_next, pick, cand;
  logic [CW-1:0]       cnt, cnt_next;
  logic                wr_q, wr_next, found, capture;
  logic [NUM_PORTS-1:0] ready_next;
  logic                ram_we_next;
  logic [ADDR_W-1:0]   ram_addr_next;
  logic [DATA_W-1:0]   ram_din_next;

  logic [ADDR_W-1:0]   addr_a  [NUM_PORTS];
  logic [DATA_W-1:0]   wdata_a [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    grant_next    = grant_id;
    cnt_next      = cnt;
    wr_next       = wr_q;
    ready_next    = '0;
    ram_we_next   = ram_write_enable;
    ram_addr_next = ram_address;
    ram_din_next  = ram_data_in;
    capture       = 1'b0;
    found         = 1'b0;
    pick          = '0;
    cand          = '0;

    // search starts one past the last served port so every requester gets a turn
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = GW'((int'(ptr) + 1 + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_next    = ISSUE;
          grant_next    = pick;
          ram_addr_next = addr_a[pick];
          ram_din_next  = wdata_a[pick];
          ram_we_next   = we[pick];
          wr_next       = we[pick];
        end
      end
      ISSUE: begin
        ram_we_next = 1'b0;
        cnt_next    = CW'(READ_LATENCY - 1);
        state_next  = WAIT;
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else begin
          capture              = !wr_q;
          ready_next[grant_id] = 1'b1;
          ptr_next             = grant_id;
          state_next           = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ram_clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      ptr              <= GW'(NUM_PORTS - 1);
      grant_id         <= '0;
      cnt              <= '0;
      wr_q             <= 1'b0;
      ready            <= '0;
      ram_write_enable <= 1'b0;
      ram_address      <= '0;
      ram_data_in      <= '0;
    end else begin
      state            <= state_next;
      ptr              <= ptr_next;
      grant_id         <= grant_next;
      cnt              <= cnt_next;
      wr_q             <= wr_next;
      ready            <= ready_next;
      ram_write_enable <= ram_we_next;
      ram_address      <= ram_addr_next;
      ram_data_in      <= ram_din_next;
    end
  end

  // rdata of a port holds until that port's next read completes
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rdata
    always_ff @(posedge ram_clk or negedge rst) begin
      if (!rst) begin
        rdata[i*DATA_W +: DATA_W] <= '0;
      end else if (capture && (grant_id == GW'(i))) begin
        rdata[i*DATA_W +: DATA_W] <= ram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: a 3-port latency-1 instance and a 2-port latency-3 instance, each with a ram model.
module tb_ram_port_arbiter;

  logic clk, rst;
  int checks, failures;

  logic [2:0]  req_a, we_a, ready_a;
  logic [47:0] addr_a;
  logic [23:0] wdata_a, rdata_a;
  logic        busy_a, rwe_a;
  logic [1:0]  gid_a;
  logic [15:0] raddr_a;
  logic [7:0]  rdin_a, rdout_a;

  logic [1:0]  req_b, we_b, ready_b;
  logic [31:0] addr_b;
  logic [15:0] wdata_b, rdata_b;
  logic        busy_b, rwe_b;
  logic [0:0]  gid_b;
  logic [15:0] raddr_b;
  logic [7:0]  rdin_b, rdout_b;

  logic [7:0] mem_a [4096];
  logic [7:0] mem_b [4096];
  logic [7:0] p1_b, p2_b;
  logic       mem_init = 1'b0;

  ram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(8), .READ_LATENCY(1)) u_a (
    .ram_clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .ready(ready_a), .rdata(rdata_a), .busy(busy_a), .grant_id(gid_a),
    .ram_write_enable(rwe_a), .ram_address(raddr_a), .ram_data_in(rdin_a), .ram_data_out(rdout_a));

  ram_port_arbiter #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(8), .READ_LATENCY(3)) u_b (
    .ram_clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .ready(ready_b), .rdata(rdata_b), .busy(busy_b), .grant_id(gid_b),
    .ram_write_enable(rwe_b), .ram_address(raddr_b), .ram_data_in(rdin_b), .ram_data_out(rdout_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ram models: a has one edge of read latency, b has three
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 4096; i++) begin
        mem_a[i[11:0]] <= 8'h00;
        mem_b[i[11:0]] <= 8'h00;
      end
      mem_a[12'h004] <= 8'h01;
      mem_a[12'h008] <= 8'h5A;
      mem_a[12'h020] <= 8'h77;
      mem_b[12'h002] <= 8'h3C;
      mem_init <= 1'b1;
    end else begin
      if (rwe_a) mem_a[raddr_a[11:0]] <= rdin_a;
      if (rwe_b) mem_b[raddr_b[11:0]] <= rdin_b;
    end
    rdout_a <= mem_a[raddr_a[11:0]];
    p1_b    <= mem_b[raddr_b[11:0]];
    p2_b    <= p1_b;
    rdout_b <= p2_b;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (ready_a !== 3'b000) begin failures++; $display("FAIL reset_ready_a got=%b exp=000", ready_a); end
    checks++; if (rdata_a !== 24'h0) begin failures++; $display("FAIL reset_rdata_a got=%h exp=0", rdata_a); end
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    checks++; if (gid_a !== 2'd0) begin failures++; $display("FAIL reset_gid_a got=%0d exp=0", gid_a); end
    checks++; if ({rwe_a, raddr_a, rdin_a} !== 25'h0) begin failures++; $display("FAIL reset_ram_bus_a got=%b/%h/%h exp=0", rwe_a, raddr_a, rdin_a); end
    checks++; if ({ready_b, rdata_b, busy_b, gid_b} !== 20'h0) begin failures++; $display("FAIL reset_outputs_b got=%b/%h/%b/%b exp=0", ready_b, rdata_b, busy_b, gid_b); end
    checks++; if ({rwe_b, raddr_b, rdin_b} !== 25'h0) begin failures++; $display("FAIL reset_ram_bus_b got=%b/%h/%h exp=0", rwe_b, raddr_b, rdin_b); end
  endtask

  task automatic test_contention();
    logic [7:0] vals [3];
    vals[0] = 8'h01; vals[1] = 8'h5A; vals[2] = 8'h77;
    we_a = 3'b000; addr_a = {16'h0020, 16'h0008, 16'h0004}; req_a = 3'b111;
    for (int t = 0; t < 6; t++) begin
      int e;
      e = t % 3;
      tick();
      checks++; if (gid_a !== 2'(e) || busy_a !== 1'b1) begin failures++; $display("FAIL contention_grant t=%0d got=%0d busy=%b exp=%0d", t, gid_a, busy_a, e); end
      tick();
      checks++; if (ready_a !== 3'b000) begin failures++; $display("FAIL contention_early_ready t=%0d got=%b exp=000", t, ready_a); end
      tick();
      checks++; if (ready_a !== (3'b001 << e)) begin failures++; $display("FAIL contention_ready t=%0d got=%b exp=%b", t, ready_a, 3'b001 << e); end
      checks++; if (rdata_a[e*8 +: 8] !== vals[e]) begin failures++; $display("FAIL contention_rdata t=%0d got=%h exp=%h", t, rdata_a[e*8 +: 8], vals[e]); end
      tick();
      checks++; if (ready_a !== 3'b000) begin failures++; $display("FAIL contention_pulse_width t=%0d got=%b exp=000", t, ready_a); end
    end
    req_a = 3'b000;
    tick();
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL contention_idle got=%b exp=0", busy_a); end
  endtask

  task automatic test_single_read();
    we_a = 3'b000; addr_a[15:0] = 16'h0004; req_a = 3'b001;
    tick();
    checks++; if (gid_a !== 2'd0 || busy_a !== 1'b1 || rwe_a !== 1'b0 || raddr_a !== 16'h0004) begin failures++; $display("FAIL single_grant got=gid%0d busy%b we%b addr%h exp=gid0 busy1 we0 addr0004", gid_a, busy_a, rwe_a, raddr_a); end
    tick();
    checks++; if (ready_a !== 3'b000) begin failures++; $display("FAIL single_early_ready got=%b exp=000", ready_a); end
    tick();
    checks++; if (ready_a !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", ready_a); end
    checks++; if (rdata_a[7:0] !== 8'h01) begin failures++; $display("FAIL single_rdata got=%h exp=01", rdata_a[7:0]); end
    req_a = 3'b000;
    tick();
    checks++; if (ready_a !== 3'b000 || busy_a !== 1'b0) begin failures++; $display("FAIL single_done got=ready%b busy%b exp=000/0", ready_a, busy_a); end
  endtask

  task automatic test_write_read();
    we_a = 3'b010; addr_a[31:16] = 16'h0100; wdata_a[15:8] = 8'hA5; req_a = 3'b010;
    tick();
    checks++; if (gid_a !== 2'd1 || rwe_a !== 1'b1 || raddr_a !== 16'h0100 || rdin_a !== 8'hA5) begin failures++; $display("FAIL write_bus got=gid%0d we%b addr%h din%h exp=gid1 we1 addr0100 dinA5", gid_a, rwe_a, raddr_a, rdin_a); end
    tick();
    checks++; if (rwe_a !== 1'b0) begin failures++; $display("FAIL write_we_drop got=%b exp=0", rwe_a); end
    tick();
    checks++; if (ready_a !== 3'b010) begin failures++; $display("FAIL write_ready got=%b exp=010", ready_a); end
    checks++; if (rdata_a[15:8] !== 8'h5A) begin failures++; $display("FAIL write_rdata_kept got=%h exp=5A", rdata_a[15:8]); end
    req_a = 3'b000; we_a = 3'b000;
    tick();
    checks++; if (ready_a !== 3'b000 || busy_a !== 1'b0) begin failures++; $display("FAIL write_done got=ready%b busy%b exp=000/0", ready_a, busy_a); end
    req_a = 3'b010;
    tick(); tick(); tick();
    checks++; if (ready_a !== 3'b010) begin failures++; $display("FAIL readback_ready got=%b exp=010", ready_a); end
    checks++; if (rdata_a[15:8] !== 8'hA5) begin failures++; $display("FAIL readback_rdata got=%h exp=A5", rdata_a[15:8]); end
    req_a = 3'b000;
    tick();
  endtask

  task automatic test_simultaneous();
    we_a = 3'b000; addr_a[15:0] = 16'h0004; addr_a[31:16] = 16'h0100;
    req_a = 3'b001;
    tick(); tick(); tick();
    checks++; if (ready_a !== 3'b001) begin failures++; $display("FAIL simul_prep_ready got=%b exp=001", ready_a); end
    req_a = 3'b000;
    tick();
    req_a = 3'b011;
    tick();
    checks++; if (gid_a !== 2'd1) begin failures++; $display("FAIL simul_first_grant got=%0d exp=1", gid_a); end
    tick(); tick();
    checks++; if (ready_a !== 3'b010 || rdata_a[15:8] !== 8'hA5) begin failures++; $display("FAIL simul_first_ready got=%b/%h exp=010/A5", ready_a, rdata_a[15:8]); end
    req_a = 3'b001;
    tick();
    checks++; if (ready_a !== 3'b000) begin failures++; $display("FAIL simul_done got=%b exp=000", ready_a); end
    tick();
    checks++; if (gid_a !== 2'd0 || busy_a !== 1'b1) begin failures++; $display("FAIL simul_second_grant got=%0d busy%b exp=0 busy1", gid_a, busy_a); end
    tick(); tick();
    checks++; if (ready_a !== 3'b001 || rdata_a[7:0] !== 8'h01) begin failures++; $display("FAIL simul_second_ready got=%b/%h exp=001/01", ready_a, rdata_a[7:0]); end
    req_a = 3'b000;
    tick();
  endtask

  task automatic test_latency3();
    we_b = 2'b00; addr_b[15:0] = 16'h0002; req_b = 2'b01;
    tick();
    checks++; if (gid_b !== 1'b0 || busy_b !== 1'b1) begin failures++; $display("FAIL lat3_grant got=%b busy%b exp=0 busy1", gid_b, busy_b); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ready_b !== 2'b00) begin failures++; $display("FAIL lat3_early_ready cyc=%0d got=%b exp=00", i + 1, ready_b); end
    end
    tick();
    checks++; if (ready_b !== 2'b01) begin failures++; $display("FAIL lat3_ready got=%b exp=01", ready_b); end
    checks++; if (rdata_b[7:0] !== 8'h3C) begin failures++; $display("FAIL lat3_rdata got=%h exp=3C", rdata_b[7:0]); end
    req_b = 2'b00;
    tick();
    checks++; if (ready_b !== 2'b00 || busy_b !== 1'b0) begin failures++; $display("FAIL lat3_done got=ready%b busy%b exp=00/0", ready_b, busy_b); end
  endtask

  task automatic test_reset_mid();
    // write aborted before the ram samples it
    we_a = 3'b100; addr_a[47:32] = 16'h0030; wdata_a[23:16] = 8'h99; req_a = 3'b100;
    tick();
    checks++; if (rwe_a !== 1'b1 || gid_a !== 2'd2) begin failures++; $display("FAIL rstmid_pre_issue got=we%b gid%0d exp=we1 gid2", rwe_a, gid_a); end
    rst = 1'b0;
    #1;
    checks++; if (rwe_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_issue_async got=we%b busy%b exp=0/0", rwe_a, busy_a); end
    tick();
    req_a = 3'b000; we_a = 3'b000; rst = 1'b1;
    // write reset while waiting for completion
    we_a = 3'b001; addr_a[15:0] = 16'h0010; wdata_a[7:0] = 8'h55; req_a = 3'b001;
    tick(); tick();
    checks++; if (busy_a !== 1'b1 || ready_a !== 3'b000) begin failures++; $display("FAIL rstmid_in_wait got=busy%b ready%b exp=1/000", busy_a, ready_a); end
    rst = 1'b0;
    #1;
    checks++; if (ready_a !== 3'b000 || busy_a !== 1'b0 || gid_a !== 2'd0) begin failures++; $display("FAIL rstmid_async_ctrl got=ready%b busy%b gid%0d exp=000/0/0", ready_a, busy_a, gid_a); end
    checks++; if ({rwe_a, raddr_a, rdin_a} !== 25'h0 || rdata_a !== 24'h0) begin failures++; $display("FAIL rstmid_async_data got=%b/%h/%h/%h exp=0", rwe_a, raddr_a, rdin_a, rdata_a); end
    tick();
    checks++; if (ready_a !== 3'b000) begin failures++; $display("FAIL rstmid_no_ready got=%b exp=000", ready_a); end
    req_a = 3'b000; we_a = 3'b000; rst = 1'b1;
    // fresh requests after release: port 0 first again
    addr_a[15:0] = 16'h0010; addr_a[47:32] = 16'h0030; req_a = 3'b101;
    tick();
    checks++; if (gid_a !== 2'd0) begin failures++; $display("FAIL rstmid_priority got=%0d exp=0", gid_a); end
    tick(); tick();
    checks++; if (ready_a !== 3'b001 || rdata_a[7:0] !== 8'h55) begin failures++; $display("FAIL rstmid_read_issued_write got=%b/%h exp=001/55", ready_a, rdata_a[7:0]); end
    req_a = 3'b100;
    tick(); tick();
    checks++; if (gid_a !== 2'd2) begin failures++; $display("FAIL rstmid_next_grant got=%0d exp=2", gid_a); end
    tick(); tick();
    checks++; if (ready_a !== 3'b100 || rdata_a[23:16] !== 8'h00) begin failures++; $display("FAIL rstmid_aborted_write got=%b/%h exp=100/00", ready_a, rdata_a[23:16]); end
    req_a = 3'b000;
    tick();
    checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=%b exp=0", busy_a); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0;
    req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
    repeat (3) tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_contention();
    test_single_read();
    test_write_read();
    test_simultaneous();
    test_latency3();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
